aes_inv_cipher_iter: RTL and testbench
======================================

AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 The block SHALL have no parameters; the cipher is fixed to AES-128 decryption with Nr = 10.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  ciphertext offered on in_data.
REQ-005 in_ready  output  1  block idle and able to accept a ciphertext.
REQ-006 in_data  input  128  ciphertext; byte i at bits [127-8i -: 8], row = i mod 4, column = i div 4 (column-major).
REQ-007 rk_idx  output  4  round-key index requested this cycle, range 0..10.
REQ-008 rk_data  input  128  round key for rk_idx, same byte layout, combinationally valid in the same cycle.
REQ-009 out_valid  output  1  plaintext available on out_data.
REQ-010 out_ready  input  1  consumer accepts plaintext.
REQ-011 out_data  output  128  plaintext, same byte layout.

Function
REQ-012 FSM states SHALL be IDLE, ROUND, FINAL and DONE, with a 4-bit round counter.
REQ-013 IDLE: in_ready=1, rk_idx=10; on in_valid, state <= in_data XOR rk_data, round <= 9, next state ROUND.
REQ-014 ROUND: rk_idx=round; state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk_data).
REQ-015 In ROUND, if round==1 the next state SHALL be FINAL; otherwise round decrements and the FSM stays in ROUND.
REQ-016 FINAL: rk_idx=0; state <= InvSubBytes(InvShiftRows(state)) XOR rk_data; next state DONE.
REQ-017 InvShiftRows SHALL map out(r,c) = in(r,(c-r) mod 4), i.e. row r rotates right by r bytes.
REQ-018 InvMixColumns SHALL use the matrix [0e 0b 0d 09] rotated per row, in GF(2^8) mod x^8+x^4+x^3+x+1.
REQ-019 DONE: out_valid=1 and out_data=state, both held stable until out_ready=1; on out_ready the next state SHALL be IDLE.
REQ-020 Latency SHALL be fixed: acceptance at cycle 0, ROUND cycles 1..9, FINAL cycle 10, out_valid high from cycle 11.
REQ-021 in_ready SHALL be 0 in every state other than IDLE; in_valid SHALL be ignored while busy.
REQ-022 Handshake in DONE with out_ready=1 and in_valid=1: the next ciphertext SHALL be accepted no earlier than the following cycle (IDLE).
REQ-023 rk_idx SHALL equal 10 in DONE, so the key store sees a stable index.
REQ-024 out_data SHALL equal the internal state register in all states; out_data is meaningful only while out_valid=1.

Reset
REQ-025 On rst_n=0 the block SHALL force IDLE, round=0, state=0, out_valid=0, in_ready=1 and rk_idx=10 immediately, without waiting for clk.
REQ-026 Reset mid-operation SHALL abandon the block, and no out_valid pulse SHALL follow release.
REQ-027 The first acceptance after reset release SHALL be possible on the first clock edge at which rst_n=1.

Structure
REQ-028 The shared package aes_pkg SHALL hold the FSM state enum, NR=10, the GF(2^8) xtime/multiply functions, and the byte-index helper.
REQ-029 The inverse S-box SHALL be a sub-module inv_sbox (8-bit in, 8-bit out, combinational ROM), instantiated 16 times.
REQ-030 InvShiftRows and InvMixColumns SHALL be combinational logic inside the block.

Verification
REQ-031 FIPS-197 C.1 key 000102..0f: in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff at cycle 11; rk_idx sequence 10,9,..,1,0.
REQ-032 FIPS-197 App. B key 2b7e151628aed2a6abf7158809cf4f3c: 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
REQ-033 out_ready held 0 for 5 cycles after out_valid -> out_data stable, in_ready=0, and in_valid pulses ignored; release -> IDLE next cycle.
REQ-034 rst_n asserted at cycle 5 of a decryption -> out_valid=0 and in_ready=1 asynchronously; the next vector decrypts correctly.
REQ-035 Back-to-back vectors with out_ready=1 and in_valid held 1 -> one plaintext every 12 cycles, all correct.
REQ-036 Random plaintexts encrypted by a reference model and then decrypted by the block (1000 vectors) -> out_data equals the original plaintext.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 inverse cipher.
// Bytes are packed column-major: byte (r,c) sits at bits [127-8*(4c+r) -: 8].
package aes_pkg;

   localparam int NR = 10;
   localparam logic [3:0] RK_LAST = 4'(NR);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUND,
      ST_FINAL,
      ST_DONE
   } fsm_state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic int byte_msb(input int r, input int c);
      return 127 - 8 * (4 * c + r);
   endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Ciphertext in, round-key fetch and plaintext out of the inverse cipher.
interface aes_inv_cipher_iter_if;

   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport slave (
      input  in_valid, in_data, rk_data, out_ready,
      output in_ready, rk_idx, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, rk_data, out_ready,
      input  in_ready, rk_idx, out_valid, out_data
   );

endinterface

// File: rtl/inv_sbox.sv
// AES inverse S-box as a combinational 256x8 ROM.
module inv_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption: one round per clock, 11-cycle latency,
// round keys fetched from an external key store through rk_idx/rk_data.
module aes_inv_cipher_iter
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   aes_inv_cipher_iter_if.slave  bus
);

   fsm_state_t   r_fsm;
   fsm_state_t   w_fsm_next;
   logic [3:0]   r_round;
   logic [3:0]   w_round_next;
   logic [127:0] r_state;
   logic [127:0] w_state_next;

   logic [127:0] w_isr;
   logic [127:0] w_isb;
   logic [127:0] w_ark;
   logic [127:0] w_imc;

   // InvShiftRows: row r rotates right by r, so out(r,c) takes in(r,c-r).
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_byte
         localparam int R   = gi % 4;
         localparam int C   = gi / 4;
         localparam int SRC = 4 * ((C - R + 4) % 4) + R;
         localparam int DST = byte_msb(R, C);

         assign w_isr[DST -: 8] = r_state[127 - 8 * SRC -: 8];

         inv_sbox u_inv_sbox (
            .i_byte (w_isr[127 - 8 * gi -: 8]),
            .o_byte (w_isb[127 - 8 * gi -: 8])
         );
      end
   endgenerate

   assign w_ark = w_isb ^ bus.rk_data;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_col
         logic [7:0] w_s0, w_s1, w_s2, w_s3;
         assign w_s0 = w_ark[byte_msb(0, gi) -: 8];
         assign w_s1 = w_ark[byte_msb(1, gi) -: 8];
         assign w_s2 = w_ark[byte_msb(2, gi) -: 8];
         assign w_s3 = w_ark[byte_msb(3, gi) -: 8];

         assign w_imc[byte_msb(0, gi) -: 8] = gf_mul(w_s0, 8'h0e) ^ gf_mul(w_s1, 8'h0b)
                                            ^ gf_mul(w_s2, 8'h0d) ^ gf_mul(w_s3, 8'h09);
         assign w_imc[byte_msb(1, gi) -: 8] = gf_mul(w_s0, 8'h09) ^ gf_mul(w_s1, 8'h0e)
                                            ^ gf_mul(w_s2, 8'h0b) ^ gf_mul(w_s3, 8'h0d);
         assign w_imc[byte_msb(2, gi) -: 8] = gf_mul(w_s0, 8'h0d) ^ gf_mul(w_s1, 8'h09)
                                            ^ gf_mul(w_s2, 8'h0e) ^ gf_mul(w_s3, 8'h0b);
         assign w_imc[byte_msb(3, gi) -: 8] = gf_mul(w_s0, 8'h0b) ^ gf_mul(w_s1, 8'h0d)
                                            ^ gf_mul(w_s2, 8'h09) ^ gf_mul(w_s3, 8'h0e);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm   <= ST_IDLE;
         r_round <= '0;
         r_state <= '0;
      end else begin
         r_fsm   <= w_fsm_next;
         r_round <= w_round_next;
         r_state <= w_state_next;
      end
   end

   // Outputs decode from registered state only, so reset forces them at once.
   always_comb begin
      w_fsm_next    = r_fsm;
      w_round_next  = r_round;
      w_state_next  = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.rk_idx    = RK_LAST;
      case (r_fsm)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               w_state_next = bus.in_data ^ bus.rk_data;
               w_round_next = 4'(NR - 1);
               w_fsm_next   = ST_ROUND;
            end
         end
         ST_ROUND: begin
            bus.rk_idx   = r_round;
            w_state_next = w_imc;
            if (r_round == 4'd1) begin
               w_fsm_next = ST_FINAL;
            end else begin
               w_round_next = r_round - 4'd1;
            end
         end
         ST_FINAL: begin
            bus.rk_idx   = 4'd0;
            w_state_next = w_ark;
            w_fsm_next   = ST_DONE;
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_fsm_next = ST_IDLE;
         end
         default: w_fsm_next = ST_IDLE;
      endcase
   end

   assign bus.out_data = r_state;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench: known-answer vectors, stall/reset/back-to-back sequences,
// and random plaintexts encrypted by a forward AES model then decrypted by the DUT.
module tb_aes_inv_cipher_iter;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   aes_inv_cipher_iter_if bus();

   aes_inv_cipher_iter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [127:0] rk_tab [0:15];
   logic [7:0]   sbox   [0:255];
   logic [3:0]   rk_seen [0:15];
   int n_checks = 0;
   int n_fail   = 0;

   // Key store: combinational lookup on the requested index.
   assign bus.rk_data = rk_tab[bus.rk_idx];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Forward S-box from its definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] p;
         logic [7:0] b;
         b = x[7:0];
         p = 8'h00;
         if (x != 0) begin
            p = 8'h01;
            for (int k = 0; k < 254; k++) p = mul(p, b);
         end
         sbox[x] = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]}
                 ^ {p[3:0], p[7:4]} ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s;
      logic [127:0] t;
      s = pt ^ rk_tab[0];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) begin
            int src;
            src = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
            t[127 - 8 * i -: 8] = sbox[s[127 - 8 * src -: 8]];
         end
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               logic [7:0] a0, a1, a2, a3;
               a0 = t[127 - 8 * (4 * c)     -: 8];
               a1 = t[127 - 8 * (4 * c + 1) -: 8];
               a2 = t[127 - 8 * (4 * c + 2) -: 8];
               a3 = t[127 - 8 * (4 * c + 3) -: 8];
               s[127 - 8 * (4 * c)     -: 8] = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
               s[127 - 8 * (4 * c + 1) -: 8] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
               s[127 - 8 * (4 * c + 2) -: 8] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
               s[127 - 8 * (4 * c + 3) -: 8] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
            end
         end else begin
            s = t;
         end
         s = s ^ rk_tab[rnd];
      end
      return s;
   endfunction

   // Offers one ciphertext and returns at the first cycle out_valid is seen.
   // lat counts clock edges from acceptance; rk_seen logs rk_idx per cycle.
   task automatic run_dut(input logic [127:0] ct, output logic [127:0] pt, output int lat);
      bus.in_data  = ct;
      bus.in_valid = 1'b1;
      rk_seen[0]   = bus.rk_idx;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      rk_seen[1] = bus.rk_idx;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (lat < 16) rk_seen[lat] = bus.rk_idx;
      end
      pt = bus.out_data;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 128'(bus.in_ready), 128'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs [5];
      logic [127:0] got;
      logic [127:0] bct [3];
      logic [127:0] bpt [3];
      int           lat;
      int           seen;
      int           nin, nout, last, cyc;

      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734};
      vecs[2] = '{128'h00000000000000000000000000000000,
                  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                  128'h00000000000000000000000000000000};
      vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3ad77bb40d7a3660a89ecaf32466ef97,
                  128'h6bc1bee22e409f96e93d7e117393172a};
      vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'hf5d3d58503b9699de785895a96fdbaaf,
                  128'hae2d8a571e03ac9c9eb76fac45af8e51};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) rk_tab[i] = '0;
      build_sbox();

      // Reset asserted between clock edges: outputs must respond without a clock.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready",  128'(bus.in_ready),  128'd1);
      check("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check("rst_rk_idx",    128'(bus.rk_idx),    128'd10);
      check("rst_out_data",  bus.out_data,        128'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Directed vectors; the first is offered before the first edge after release.
      for (int i = 0; i < 5; i++) begin
         expand(vecs[i].key);
         check($sformatf("v%0d_model_enc", i), encrypt(vecs[i].pt), vecs[i].ct);
         run_dut(vecs[i].ct, got, lat);
         check($sformatf("v%0d_plaintext", i), got, vecs[i].pt);
         check($sformatf("v%0d_latency", i), 128'(lat), 128'd11);
         $display("vec %0d: ct=%h pt=%h latency=%0d", i, vecs[i].ct, got, lat);
         if (i == 0) begin
            for (int k = 0; k < 12; k++) begin
               check($sformatf("v0_rk_idx_c%0d", k), 128'(rk_seen[k]),
                     (k == 11) ? 128'd10 : 128'(10 - k));
            end
         end
         wait_idle($sformatf("v%0d_back_to_idle", i));
      end

      // Consumer stall: output held, busy, in_valid pulses ignored.
      expand(vecs[1].key);
      bus.out_ready = 1'b0;
      run_dut(vecs[1].ct, got, lat);
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = k[0];
         bus.in_data  = {4{$urandom}};
         @(posedge clk); #1;
         check($sformatf("stall%0d_out_valid", k), 128'(bus.out_valid), 128'd1);
         check($sformatf("stall%0d_out_data", k),  bus.out_data, vecs[1].pt);
         check($sformatf("stall%0d_in_ready", k),  128'(bus.in_ready), 128'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release_in_ready",  128'(bus.in_ready),  128'd1);
      check("stall_release_out_valid", 128'(bus.out_valid), 128'd0);
      $display("stall: pt=%h held 5 cycles", vecs[1].pt);

      // Reset at cycle 5 of a decryption.
      expand(vecs[0].key);
      bus.in_data  = vecs[0].ct;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      #3 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
      check("midrst_in_ready",  128'(bus.in_ready),  128'd1);
      check("midrst_rk_idx",    128'(bus.rk_idx),    128'd10);
      @(posedge clk);
      #2 rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      check("midrst_no_out_valid", 128'(seen), 128'd0);
      run_dut(vecs[0].ct, got, lat);
      check("midrst_next_plaintext", got, vecs[0].pt);
      $display("midrst: ct=%h pt=%h latency=%0d", vecs[0].ct, got, lat);
      wait_idle("midrst_back_to_idle");

      // Back-to-back with in_valid held high: one result every 12 cycles.
      expand(vecs[1].key);
      bct[0] = vecs[1].ct; bpt[0] = vecs[1].pt;
      bct[1] = vecs[3].ct; bpt[1] = vecs[3].pt;
      bct[2] = vecs[4].ct; bpt[2] = vecs[4].pt;
      nin = 0; nout = 0; last = 0; cyc = 0;
      bus.in_valid = 1'b1;
      while (nout < 3 && cyc < 100) begin
         if (bus.in_ready) begin
            if (nin < 3) begin
               bus.in_data = bct[nin];
               nin++;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         if (bus.out_valid) begin
            check($sformatf("b2b%0d_plaintext", nout), bus.out_data, bpt[nout]);
            if (nout > 0) check($sformatf("b2b%0d_interval", nout), 128'(cyc - last), 128'd12);
            $display("b2b %0d: pt=%h cycle=%0d", nout, bus.out_data, cyc);
            last = cyc;
            nout++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      check("b2b_count", 128'(nout), 128'd3);
      wait_idle("b2b_back_to_idle");

      // Random round trips through the forward model.
      for (int n = 0; n < 1000; n++) begin
         logic [127:0] key;
         logic [127:0] pt;
         logic [127:0] ct;
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         expand(key);
         ct = encrypt(pt);
         run_dut(ct, got, lat);
         check($sformatf("rand%0d_plaintext", n), got, pt);
         $display("rand %0d: key=%h ct=%h pt=%h", n, key, ct, got);
         wait_idle($sformatf("rand%0d_back_to_idle", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
